regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_rdport.sv | 34 +++
 rtl/regfile_sb.sv | 64 ++++++
 tb/tb_regfile_sb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, zero-register constant and popcount helper for regfile_sb
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO = 0;
  function automatic int popcount(input logic [1023:0] v);
    int c;
    c = 0;
    for (int k = 0; k < 1024; k++) c += int'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port (zero, optional write-through bypass, array read, busy gating); bypass enabled by REGFILE_BYPASS_EN
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic [AW-1:0]          i_raddr,
  input  logic [NREGS*XLEN-1:0]  i_mem,
  input  logic [NREGS-1:0]       i_pend,
  input  logic                   i_wen,
  input  logic [AW-1:0]          i_waddr,
  input  logic [XLEN-1:0]        i_wdata,
  input  logic                   i_rsv_en,
  input  logic [AW-1:0]          i_rsv_addr,
  output logic [XLEN-1:0]        o_rdata,
  output logic                   o_busy
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic w_zero, w_hit, w_rsv;
  // select zero, in-flight write data or stored value; a bypassed write clears busy unless re-reserved
  always_comb begin
    w_zero = i_raddr == AW'(REG_ZERO);
    w_hit = BYP && i_wen && i_waddr == i_raddr && !w_zero;
    w_rsv = i_rsv_en && i_rsv_addr == i_raddr;
    o_rdata = w_zero ? '0 : w_hit ? i_wdata : i_mem[i_raddr*XLEN +: XLEN];
    o_busy = w_hit ? w_rsv : i_pend[i_raddr];
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with pending-write scoreboard; optional bypass via REGFILE_BYPASS_EN
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 writeEn,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      writeData,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  input  logic                 rsvEn,
  input  logic [AW-1:0]        rsvAddr,
  output logic [NRD-1:0]       busy,
  output logic [AW:0]          pendCount
);
  logic [NREGS-1:1][XLEN-1:0] r_mem;
  logic [NREGS-1:1] r_pend;
  logic [AW:0] r_cnt;
  logic [NREGS*XLEN-1:0] w_mem_flat;
  logic [NREGS-1:0] w_pend_flat;
  logic w_wr, w_rsv, w_inc, w_dec;
  assign w_mem_flat = {r_mem, {XLEN{1'b0}}};
  assign w_pend_flat = {r_pend, 1'b0};
  assign w_wr = writeEn && waddr != AW'(REG_ZERO);
  assign w_rsv = rsvEn && rsvAddr != AW'(REG_ZERO);
  assign w_inc = w_rsv && !w_pend_flat[rsvAddr];
  assign w_dec = w_wr && w_pend_flat[waddr] && !(w_rsv && rsvAddr == waddr);
  assign pendCount = r_cnt;
  // writeback updates data and releases the register; a same-edge reserve wins the pend bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_pend <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[waddr] <= writeData;
        r_pend[waddr] <= 1'b0;
      end
      if (w_rsv) r_pend[rsvAddr] <= 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rd (
      .i_raddr(raddr[i*AW +: AW]),
      .i_mem(w_mem_flat),
      .i_pend(w_pend_flat),
      .i_wen(writeEn),
      .i_waddr(waddr),
      .i_wdata(writeData),
      .i_rsv_en(rsvEn),
      .i_rsv_addr(rsvAddr),
      .o_rdata(rdata[i*XLEN +: XLEN]),
      .o_busy(busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb (default and NRD=3/XLEN=64/NREGS=16 instances); REGFILE_BYPASS_EN selects bypass expectations
module tb_regfile_sb;
  import regfile_pkg::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic we = 1'b0, re = 1'b0;
  logic [4:0] wa = '0, radr = '0;
  logic [31:0] wd = '0;
  logic [9:0] ra = '0;
  logic [63:0] rd;
  logic [1:0] bz;
  logic [5:0] pc;
  logic we1 = 1'b0, re1 = 1'b0;
  logic [3:0] wa1 = '0, radr1 = '0;
  logic [63:0] wd1 = '0;
  logic [11:0] ra1 = '0;
  logic [191:0] rd1;
  logic [2:0] bz1;
  logic [4:0] pc1;
  int checks = 0, fails = 0;
  logic [31:0] m_mem [32];
  logic [31:0] m_pend;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .writeEn(we), .waddr(wa), .writeData(wd),
    .raddr(ra), .rdata(rd), .rsvEn(re), .rsvAddr(radr), .busy(bz), .pendCount(pc)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .writeEn(we1), .waddr(wa1), .writeData(wd1),
    .raddr(ra1), .rdata(rd1), .rsvEn(re1), .rsvAddr(radr1), .busy(bz1), .pendCount(pc1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    chk("reset_pc_initial", 64'(pc), 64'd0);
    rst_n = 1; we = 1; wa = 5; wd = 32'hDEADBEEF;
    tick();
    we = 0; ra = {5'd0, 5'd5};
    #1 chk("x5_written", 64'(rd[31:0]), 64'hDEADBEEF);
    rst_n = 0; we = 1; wa = 5; wd = 32'h1; re = 1; radr = 5;
    tick();
    rst_n = 1; we = 0; re = 0;
    #1 chk("reset_rdata", 64'(rd[31:0]), 64'd0);
    chk("reset_busy", 64'(bz[0]), 64'd0);
    chk("reset_pc", 64'(pc), 64'd0);
    we = 1; wa = 0; wd = 32'hFFFFFFFF; re = 1; radr = 0; ra = '0;
    #1 chk("x0_rdata_same_cycle", 64'(rd[31:0]), 64'd0);
    tick();
    we = 0; re = 0;
    #1 chk("x0_rdata", 64'(rd[31:0]), 64'd0);
    chk("x0_busy", 64'(bz[0]), 64'd0);
    chk("x0_pc", 64'(pc), 64'd0);
    re = 1; radr = 7;
    tick();
    re = 0; ra = {5'd7, 5'd0};
    #1 chk("x7_busy_reserved", 64'(bz[1]), 64'd1);
    chk("x7_pc_reserved", 64'(pc), 64'd1);
    we = 1; wa = 7; wd = 32'h12345678;
    #1 chk("x7_pre_rdata", 64'(rd[63:32]), BYP ? 64'h12345678 : 64'd0);
    chk("x7_pre_busy", 64'(bz[1]), BYP ? 64'd0 : 64'd1);
    tick();
    we = 0;
    #1 chk("x7_rdata", 64'(rd[63:32]), 64'h12345678);
    chk("x7_busy_cleared", 64'(bz[1]), 64'd0);
    chk("x7_pc_cleared", 64'(pc), 64'd0);
    re = 1; radr = 3;
    tick();
    re = 0; ra = {5'd3, 5'd0}; we = 1; wa = 3; wd = 32'hA5A5A5A5;
    #1 chk("x3_bypass_rdata", 64'(rd[63:32]), BYP ? 64'hA5A5A5A5 : 64'd0);
    chk("x3_bypass_busy", 64'(bz[1]), BYP ? 64'd0 : 64'd1);
    tick();
    we = 0;
    #1 chk("x3_rdata", 64'(rd[63:32]), 64'hA5A5A5A5);
    chk("x3_busy", 64'(bz[1]), 64'd0);
    chk("x3_pc", 64'(pc), 64'd0);
    we = 1; wa = 3; wd = 32'h1; re = 1; radr = 3;
    #1 chk("x3_rersv_pre_rdata", 64'(rd[63:32]), BYP ? 64'h1 : 64'hA5A5A5A5);
    chk("x3_rersv_pre_busy", 64'(bz[1]), BYP ? 64'd1 : 64'd0);
    tick();
    we = 0; re = 0;
    #1 chk("x3_rersv_rdata", 64'(rd[63:32]), 64'h1);
    chk("x3_rersv_busy", 64'(bz[1]), 64'd1);
    chk("x3_rersv_pc", 64'(pc), 64'd1);
    we = 1; wa = 3; wd = 32'h2;
    tick();
    we = 0;
    #1 chk("x3_release_pc", 64'(pc), 64'd0);
    re = 1; radr = 9;
    tick();
    we = 1; wa = 9; wd = 32'h55;
    tick();
    we = 0; re = 0; ra = {5'd0, 5'd9};
    #1 chk("x9_rdata", 64'(rd[31:0]), 64'h55);
    chk("x9_busy", 64'(bz[0]), 64'd1);
    chk("x9_pc", 64'(pc), 64'd1);
    we = 1; wa = 9;
    tick();
    we = 0;
    #1 chk("x9_release_pc", 64'(pc), 64'd0);
    ra = {5'd7, 5'd7};
    #1 chk("dual_port0", 64'(rd[31:0]), 64'h12345678);
    chk("dual_port1", 64'(rd[63:32]), 64'h12345678);
    for (int r = 1; r < 32; r++) begin
      re = 1; radr = 5'(r);
      tick();
    end
    re = 0; ra = {5'd31, 5'd1};
    #1 chk("all_pending_pc", 64'(pc), 64'd31);
    chk("all_pending_busy", 64'(bz), 64'd3);
    re = 1; radr = 5;
    tick();
    re = 0;
    #1 chk("rersv_pending_pc", 64'(pc), 64'd31);
    we1 = 1; wa1 = 15; wd1 = 64'h0123456789ABCDEF;
    tick();
    we1 = 0; ra1 = {4'd15, 4'd15, 4'd15};
    #1 chk("p3_port0", rd1[63:0], 64'h0123456789ABCDEF);
    chk("p3_port1", rd1[127:64], 64'h0123456789ABCDEF);
    chk("p3_port2", rd1[191:128], 64'h0123456789ABCDEF);
    chk("p3_busy", 64'(bz1), 64'd0);
    re1 = 1; radr1 = 15;
    tick();
    re1 = 0;
    #1 chk("p3_busy_rsv", 64'(bz1), 64'd7);
    chk("p3_pc", 64'(pc1), 64'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    m_pend = '0;
    for (int r = 0; r < 32; r++) m_mem[r] = '0;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(1)); wa = 5'($urandom); wd = $urandom;
      re = 1'($urandom_range(1)); radr = 5'($urandom);
      if (we && wa != 0) begin
        m_mem[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (re && radr != 0) m_pend[radr] = 1'b1;
      tick();
      we = 0; re = 0; ra = 10'($urandom);
      #1 chk("sweep_pc", 64'(pc), 64'(popcount(1024'(m_pend))));
      chk("sweep_rdata", 64'(rd[63:32]), 64'(m_mem[ra[9:5]]));
      chk("sweep_busy", 64'(bz[0]), 64'(m_pend[ra[4:0]]));
    end
    for (int r = 0; r < 32; r++) begin
      ra = {5'(r), 5'(r)};
      #1 chk("final_rdata", 64'(rd[31:0]), 64'(m_mem[r]));
      chk("final_busy", 64'(bz[1]), 64'(m_pend[r]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
